display_stream_driver: RTL and testbench

DISPLAY_STREAM_DRIVER -- requirements
Module: display_stream_driver

---
 rtl/display_pkg.sv | 20 ++
 rtl/display_stream_driver_if.sv | 40 ++++
 rtl/disp_fifo.sv | 55 +++++
 rtl/display_stream_driver.sv | 113 +++++++++++
 tb/tb_display_stream_driver.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Display stream driver shared types.
// State encoding and default geometry constants.
package display_pkg;

  localparam int DEF_DATA_W   = 24;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } disp_state_e;

  // Counter width that stays legal for a range of one
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_stream_driver_if.sv
// Pixel stream handshake bundle.
// Input side valid/ready plus output side with frame markers.
interface display_stream_driver_if
  import display_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [DATA_W-1:0] in_rgb;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_rgb;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic              out_eol;

  modport slave (
    input  in_rgb,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_rgb,
    output out_valid,
    output out_sof,
    output out_eol
  );

  modport master (
    output in_rgb,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_rgb,
    input  out_valid,
    input  out_sof,
    input  out_eol
  );

endinterface

// File: rtl/disp_fifo.sv
// Pixel buffer for the display stream driver.
// Power-of-two depth, pointers wrap naturally.
module disp_fifo #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             push,
  input  logic                             pop,
  input  logic [DATA_W-1:0]                din,
  output logic [DATA_W-1:0]                dout,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !clear &&
                   (count != CW'(FIFO_DEPTH));
  assign do_pop  = pop && !clear && (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/display_stream_driver.sv
// Buffers pixels and paces them out in raster order.
// Tracks x/y, frame markers and mid-frame starvation.
module display_stream_driver
  import display_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  display_stream_driver_if.slave          strm,
  output logic                            frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_level,
  output logic [15:0]                     underflow_cnt,
  output logic                            busy
);

  localparam int XW = cnt_w(H_ACTIVE);
  localparam int YW = cnt_w(V_ACTIVE);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  disp_state_e       state;
  disp_state_e       state_nxt;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] head;
  logic              empty;
  logic              in_ready;
  logic              out_valid;
  logic              push;
  logic              pop;
  logic              last_x;
  logic              last_y;
  logic              starve;

  disp_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (strm.in_rgb),
    .dout  (head),
    .count (count)
  );

  // rst_n gates ready so every output reads 0 in reset
  assign in_ready  = rst_n && !clear &&
                     (count < CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign out_valid = (state == ACTIVE) && !empty;
  assign push      = strm.in_valid && in_ready;
  assign pop       = out_valid && strm.out_ready;
  assign last_x    = (x == XW'(H_ACTIVE-1));
  assign last_y    = (y == YW'(V_ACTIVE-1));
  assign starve    = (state == ACTIVE) && empty &&
                     ((x != '0) || (y != '0));

  assign strm.in_ready  = in_ready;
  assign strm.out_valid = out_valid;
  assign strm.out_rgb   = out_valid ? head : '0;
  assign strm.out_sof   = out_valid && (x == '0) &&
                          (y == '0);
  assign strm.out_eol   = out_valid && last_x;

  assign frame_done = (state == DONE);
  assign fill_level = count;
  assign busy       = (state != IDLE) || !empty;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!empty) state_nxt = ACTIVE;
      ACTIVE:  if (pop && last_x && last_y)
                 state_nxt = DONE;
      DONE:    state_nxt = empty ? IDLE : ACTIVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      underflow_cnt <= '0;
    end else if (clear) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        if (last_x) begin
          x <= '0;
          y <= last_y ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
      if (starve && (underflow_cnt != 16'hFFFF))
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_display_stream_driver.sv
// Directed and randomized checks for display_stream_driver.
// 4x2 frame, 4-entry buffer.
module tb_display_stream_driver;
  import display_pkg::*;

  localparam int DW  = 24;
  localparam int DEP = 4;
  localparam int H   = 4;
  localparam int V   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        frame_done;
  logic        busy;
  logic [2:0]  fill_level;
  logic [15:0] underflow_cnt;

  display_stream_driver_if #(.DATA_W(DW)) bus ();

  display_stream_driver #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEP),
    .H_ACTIVE   (H),
    .V_ACTIVE   (V)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .strm          (bus.slave),
    .frame_done    (frame_done),
    .fill_level    (fill_level),
    .underflow_cnt (underflow_cnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rgb;
    logic          sof;
    logic          eol;
    int            cyc;
  } pop_t;

  int            total;
  int            bad;
  int            cycle;
  logic [DW-1:0] src[$];
  pop_t          pops[$];
  int            push_cyc[$];
  int            done_cyc[$];
  logic [DW-1:0] q[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    src.delete();
    pops.delete();
    push_cyc.delete();
    done_cyc.delete();
    cycle = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_rgb    = '0;
    bus.out_ready = 1'b0;
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_rgb"}, bus.out_rgb, 0);
    chk({tag, "_sof"}, bus.out_sof, 0);
    chk({tag, "_eol"}, bus.out_eol, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_fill"}, fill_level, 0);
    chk({tag, "_underflow"}, underflow_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // One clock: drive from src, log handshakes, advance
  task automatic cyc();
    pop_t p;
    bus.in_valid = (src.size() > 0);
    bus.in_rgb   = (src.size() > 0) ? src[0] : '0;
    #1;
    if (bus.in_valid && bus.in_ready) begin
      void'(src.pop_front());
      push_cyc.push_back(cycle);
    end
    if (bus.out_valid && bus.out_ready) begin
      p.rgb = bus.out_rgb;
      p.sof = bus.out_sof;
      p.eol = bus.out_eol;
      p.cyc = cycle;
      pops.push_back(p);
    end
    if (frame_done) done_cyc.push_back(cycle);
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Frame of pixels 1..H*V in raster order
  task automatic check_frame(input string tag);
    int n;
    int last;
    n = pops.size();
    chk({tag, "_npop"}, n, H * V);
    for (int i = 0; i < n && i < H * V; i++) begin
      chk($sformatf("%s_rgb%0d", tag, i),
          pops[i].rgb, i + 1);
      chk($sformatf("%s_sof%0d", tag, i),
          pops[i].sof, (i == 0));
      chk($sformatf("%s_eol%0d", tag, i),
          pops[i].eol, (i % H == H - 1));
    end
    chk({tag, "_ndone"}, done_cyc.size(), 1);
    last = (n > 0) ? pops[n-1].cyc : -100;
    chk({tag, "_done_cyc"},
        (done_cyc.size() > 0) ? done_cyc[0] : -1,
        last + 1);
  endtask

  task automatic rand_phase(input int ncyc);
    int  idx;
    int  stall;
    bit  pend_done;
    bit  exp_ir;
    bit  pop;
    idx = 0;
    stall = 0;
    pend_done = 0;
    q.delete();
    for (int c = 0; c < ncyc; c++) begin
      clear         = ($urandom_range(0, 99) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_rgb    = DW'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ir = (q.size() < DEP) && !clear;
      chk("r_in_ready", bus.in_ready, exp_ir);
      chk("r_fill", fill_level, q.size());
      chk("r_done", frame_done, pend_done);
      if (bus.out_valid) begin
        chk("r_nonempty", (q.size() > 0), 1);
        if (q.size() > 0) chk("r_rgb", bus.out_rgb, q[0]);
        chk("r_sof", bus.out_sof, (idx == 0));
        chk("r_eol", bus.out_eol, (idx % H == H - 1));
      end
      if (frame_done) chk("r_done_nv", bus.out_valid, 0);
      pop = bus.out_valid && bus.out_ready;
      if (q.size() > 0 && bus.out_ready && !pop && !clear)
      begin
        stall++;
        chk("r_live", (stall > 2), 0);
      end else begin
        stall = 0;
      end
      pend_done = 0;
      if (clear) begin
        q.delete();
        idx = 0;
      end else begin
        if (pop && q.size() > 0) begin
          void'(q.pop_front());
          if (idx == H * V - 1) begin
            idx = 0;
            pend_done = 1;
          end else begin
            idx++;
          end
        end
        if (bus.in_valid && exp_ir) q.push_back(bus.in_rgb);
      end
      @(posedge clk);
      #1;
    end
    clear = 1'b0;
  endtask

  initial begin
    logic [15:0] uf0;
    bit          stable;
    total = 0;
    bad   = 0;
    cycle = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_rgb    = '0;
    bus.out_ready = 1'b0;
    #3;
    chk_zero("rst");

    // Streaming frame with display always ready
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) src.push_back(DW'(k));
    repeat (20) cyc();
    check_frame("s1");
    chk("s1_idle_lat",
        (pops.size() > 0 && push_cyc.size() > 0) ?
          pops[0].cyc - push_cyc[0] : -1, 2);

    // Display stalled: buffer fills, head held
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) src.push_back(DW'(k));
    stable = 1;
    repeat (8) begin
      cyc();
      if (bus.out_valid &&
          (bus.out_rgb !== 24'h1 || bus.out_sof !== 1'b1))
        stable = 0;
    end
    chk("s2_left", src.size(), 1);
    chk("s2_npush", push_cyc.size(), 4);
    chk("s2_last_push",
        (push_cyc.size() == 4) ? push_cyc[3] : -1, 3);
    chk("s2_fill", fill_level, 4);
    chk("s2_in_ready", bus.in_ready, 0);
    chk("s2_valid", bus.out_valid, 1);
    chk("s2_rgb", bus.out_rgb, 1);
    chk("s2_stable", stable, 1);
    bus.out_ready = 1'b1;
    cyc();
    chk("s2_fullpop_npush", push_cyc.size(), 4);
    chk("s2_fullpop_fill", fill_level, 3);
    chk("s2_fullpop_npop", pops.size(), 1);

    // Input starves mid-line
    do_reset();
    bus.out_ready = 1'b1;
    src.push_back(24'h1);
    src.push_back(24'h2);
    repeat (6) cyc();
    for (int k = 3; k <= 8; k++) src.push_back(DW'(k));
    repeat (14) cyc();
    chk("s3_underflow", underflow_cnt, 3);
    check_frame("s3");
    chk("s3_active_lat",
        (pops.size() > 2 && push_cyc.size() > 2) ?
          pops[2].cyc - push_cyc[2] : -1, 1);

    // Soft clear mid-line with 3 buffered
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) src.push_back(DW'(k));
    repeat (3) cyc();
    bus.out_ready = 1'b0;
    cyc();
    chk("s4_fill_pre", fill_level, 3);
    uf0 = underflow_cnt;
    clear = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_rgb    = 24'h55;
    bus.out_ready = 1'b1;
    #1;
    chk("s4_in_ready_clr", bus.in_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    chk("s4_fill", fill_level, 0);
    chk("s4_busy", busy, 0);
    chk("s4_valid", bus.out_valid, 0);
    chk("s4_underflow", underflow_cnt, uf0);
    clear_log();
    src.push_back(24'hA);
    repeat (4) cyc();
    chk("s4_npop", pops.size(), 1);
    chk("s4_rgb", (pops.size() > 0) ? pops[0].rgb : 0, 24'hA);
    chk("s4_sof", (pops.size() > 0) ? pops[0].sof : 0, 1);

    // Asynchronous reset mid-frame
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) src.push_back(DW'(k));
    repeat (4) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("s5_rst");
    @(posedge clk);
    #1;
    clear_log();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) src.push_back(DW'(k));
    repeat (20) cyc();
    check_frame("s5");

    // Random traffic against queue model
    do_reset();
    rand_phase(800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
